// File: rtl/cla_multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle CLA adder: FSM encoding, lookahead group
// width, and the elaboration-time helpers used to size and validate the datapath.
package cla_multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int GROUP_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // WIDTH must split into whole slices, and each slice into whole lookahead groups.
  function automatic bit params_legal(input int width, input int slice);
    return (width > 0) && (slice > 0) && ((width % slice) == 0) &&
           ((slice % GROUP_W) == 0);
  endfunction

endpackage

// File: rtl/cla_multicycle_adder_cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder built from 4-bit generate/propagate
// groups; group carries chain through each group's G/P terms.
module cla_slice
  import cla_multicycle_adder_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic [SLICE:1]   carry
);

  localparam int NGROUP = SLICE / GROUP_W;

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic             grp_g;
  logic             grp_p;
  int               base;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    c[0]  = cin;
    grp_g = 1'b0;
    grp_p = 1'b0;
    base  = 0;
    for (int j = 0; j < NGROUP; j++) begin
      base       = j * GROUP_W;
      c[base+1]  = g[base] | (p[base] & c[base]);
      c[base+2]  = g[base+1] | (p[base+1] & g[base]) |
                   (p[base+1] & p[base] & c[base]);
      c[base+3]  = g[base+2] | (p[base+2] & g[base+1]) |
                   (p[base+2] & p[base+1] & g[base]) |
                   (p[base+2] & p[base+1] & p[base] & c[base]);
      grp_g      = g[base+3] | (p[base+3] & g[base+2]) |
                   (p[base+3] & p[base+2] & g[base+1]) |
                   (p[base+3] & p[base+2] & p[base+1] & g[base]);
      grp_p      = &p[base +: GROUP_W];
      c[base+4]  = grp_g | (grp_p & c[base]);
    end
    sum   = p ^ c[SLICE-1:0];
    carry = c[SLICE:1];
  end

endmodule

// File: rtl/cla_multicycle_adder.sv
// Multi-cycle adder/subtractor: one cla_slice is time-multiplexed over the operand,
// with the inter-slice carry held in a register between cycles.
module cla_multicycle_adder
  import cla_multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (!params_legal(WIDTH, SLICE)) begin : g_param_check
    $error("cla_multicycle_adder: WIDTH must be a multiple of SLICE, SLICE a multiple of 4");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic [SLICE:1]   slice_carry;
  logic             unused_carries;

  assign slice_a = a_q[int'(idx_q)*SLICE +: SLICE];
  assign slice_b = b_q[int'(idx_q)*SLICE +: SLICE];

  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  // Only the top two slice carries feed c_out and the overflow flag.
  assign unused_carries = ^slice_carry[SLICE-2:1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction is A + ~B + 1, so the operand is inverted once at latch time.
          a_d     = in1;
          b_d     = sub ? ~in2 : in2;
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[int'(idx_q)*SLICE +: SLICE] = slice_sum;
        carry_d = slice_carry[SLICE];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_d;
          cout_d  = slice_carry[SLICE];
          ovf_d   = slice_carry[SLICE] ^ slice_carry[SLICE-1];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_multicycle_adder.sv
// Bench for cla_multicycle_adder: arithmetic reference model with per-cycle compare,
// plus directed vectors with hand-computed results and handshake timing checks.
module tb_cla_multicycle_adder;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  cla_multicycle_adder #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .c_in     (c_in),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference arithmetic: plain wide add / subtract and the two's-complement sign rule.
  function automatic void ref_calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic s,
                                   output logic [WIDTH-1:0] rs, output logic rc,
                                   output logic ro);
    logic [WIDTH:0] r;
    if (s) begin
      r  = {1'b0, a} - {1'b0, b};
      rs = r[WIDTH-1:0];
      rc = ~r[WIDTH];
      ro = (a[WIDTH-1] != b[WIDTH-1]) && (rs[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      rs = r[WIDTH-1:0];
      rc = r[WIDTH];
      ro = (a[WIDTH-1] == b[WIDTH-1]) && (rs[WIDTH-1] != a[WIDTH-1]);
    end
  endfunction

  // Transaction-level model: an accepted request is busy for NSLICE cycles, then done.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_sum  = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf  = 1'b0;
  logic [WIDTH-1:0] p_sum;
  logic             p_cout;
  logic             p_ovf;
  int               m_cnt  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_done = 1'b0;
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        ref_calc(in1, in2, c_in, sub, p_sum, p_cout, p_ovf);
        m_busy = 1'b1;
        m_cnt  = NSLICE;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'd0, busy}, {63'd0, m_busy});
      check("done", {63'd0, done}, {63'd0, m_done});
      check("sum", sum, m_sum);
      check("c_out", {63'd0, c_out}, {63'd0, m_cout});
      check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    end
  end

  task automatic wait_done(input string name, output int tdone);
    bit seen;
    seen  = 1'b0;
    tdone = -1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        tdone = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
  endtask

  task automatic check_result(input string name, input logic [WIDTH-1:0] es,
                              input logic ec, input logic eo);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, {63'd0, c_out}, {63'd0, ec});
    check({name, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic s, input logic [WIDTH-1:0] es,
                        input logic ec, input logic eo, input string name);
    int t0;
    int tdone;
    @(posedge clk);
    #1;
    in1   = a;
    in2   = b;
    c_in  = ci;
    sub   = s;
    start = 1'b1;
    t0    = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    in1   = ~a;
    in2   = ~b;
    sub   = ~s;
    wait_done(name, tdone);
    if (tdone >= 0) begin
      check({name, "_latency"}, 64'(tdone - t0), 64'(NSLICE + 1));
      check_result(name, es, ec, eo);
    end
  endtask

  initial begin
    int n;
    int t1;
    int td;
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    c_in  = 1'b0;
    sub   = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check_result("reset", 64'd0, 1'b0, 1'b0);
    rst = 1'b0;

    run_op(64'd3245, 64'd16785, 1'b0, 1'b0, 64'd20030, 1'b0, 1'b0, "add");
    run_op(64'd3245, 64'd16785, 1'b1, 1'b0, 64'd20031, 1'b0, 1'b0, "add_cin");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, "chain");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
           1'b0, 1'b1, "sovf");
    run_op(64'd25000, 64'd40535, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_C351, 1'b0, 1'b0,
           "sub_neg");
    run_op(64'd40535, 64'd25000, 1'b0, 1'b1, 64'd15535, 1'b1, 1'b0, "sub_pos");
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
           1'b1, 1'b1, "sub_ovf");
    run_op(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
           64'h0000_0001_0001_0000, 1'b0, 1'b0, "slice_carry");

    // start held across the busy window yields a single operation
    @(posedge clk);
    #1;
    in1   = 64'd1;
    in2   = 64'd2;
    c_in  = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("held_start_dones", 64'(n), 64'd1);
    check("held_start_sum", sum, 64'd3);

    // back-to-back: start asserted in the DONE cycle
    @(posedge clk);
    #1;
    in1   = 64'd100;
    in2   = 64'd23;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("b2b_first", td);
    if (td >= 0) begin
      check("b2b_first_sum", sum, 64'd123);
      in1   = 64'd1000;
      in2   = 64'd1;
      sub   = 1'b1;
      start = 1'b1;
      t1    = td;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("b2b_second", td);
      if (td >= 0) begin
        check("b2b_gap", 64'(td - t1), 64'(NSLICE + 1));
        check_result("b2b_second", 64'd999, 1'b1, 1'b0);
      end
    end

    // reset during the second busy cycle aborts the operation
    @(posedge clk);
    #1;
    in1   = 64'd5;
    in2   = 64'd7;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check_result("abort", 64'd0, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
